// File: rtl/el2_pkg.sv
// Shared IFU types: the fetch-buffer entry layout consumed by both the fetch buffer and the aligner.
package el2_pkg;

  typedef struct packed {
    logic [31:1] pc;
    logic [31:0] data;
    logic [1:0]  val;
    logic [1:0]  fault;
    logic [1:0]  fault_type;
  } el2_ifu_fb_entry_t;

endpackage

// File: rtl/el2_ifu_fetch_buf.sv
// IFU fetch buffer: a small FIFO of F-stage fetch results feeding the aligner.
// Optional same-cycle bypass into an empty buffer is enabled by defining EL2_IFU_FB_BYPASS_EN.
module el2_ifu_fetch_buf
  import el2_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_l,
  input  logic                       exu_flush_final,
  input  logic                       ic_hit_f,
  input  logic [1:0]                 ic_fetch_val_f,
  input  logic [31:0]                ic_data_f,
  input  logic [1:0]                 ic_access_fault_f,
  input  logic [1:0]                 ic_access_fault_type_f,
  input  logic [31:1]                ifu_fetch_pc_f,
  input  logic                       aln_pop,
  output logic                       fb_valid,
  output logic [31:0]                fb_data,
  output logic [1:0]                 fb_val,
  output logic [31:1]                fb_pc,
  output logic [1:0]                 fb_fault,
  output logic [1:0]                 fb_fault_type,
  output logic [$clog2(DEPTH+1)-1:0] fb_count,
  output logic                       fb_stall,
  output logic                       fb_overflow_err
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  el2_ifu_fb_entry_t mem [DEPTH];
  el2_ifu_fb_entry_t in_entry;
  el2_ifu_fb_entry_t head;

  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             push_req, pop, full, bypass;
  logic             wr_en, rd_adv, overflow_d;

  assign in_entry = '{pc:         ifu_fetch_pc_f,
                      data:       ic_data_f,
                      val:        ic_fetch_val_f,
                      fault:      ic_access_fault_f,
                      fault_type: ic_access_fault_type_f};

  assign push_req = (|ic_fetch_val_f) & (ic_hit_f | (|ic_access_fault_f)) & ~exu_flush_final;
  assign full     = (count == CNT_W'(DEPTH));

`ifdef EL2_IFU_FB_BYPASS_EN
  // push_req already excludes flush, so bypass is off during exu_flush_final
  assign bypass = push_req & (count == '0);
`else
  assign bypass = 1'b0;
`endif

  assign fb_valid = ((count != '0) | bypass) & ~exu_flush_final;
  assign pop      = aln_pop & fb_valid;

  // A bypassed entry that the aligner takes immediately never lands in storage
  assign wr_en      = push_req & (~full | pop) & ~(bypass & pop);
  assign rd_adv     = pop & ~bypass;
  assign overflow_d = push_req & full & ~pop;

  assign head          = bypass ? in_entry : mem[rd_ptr];
  assign fb_data       = head.data;
  assign fb_val        = head.val;
  assign fb_pc         = head.pc;
  assign fb_fault      = head.fault;
  assign fb_fault_type = head.fault_type;
  assign fb_count      = count;
  assign fb_stall      = (count >= CNT_W'(DEPTH-1));

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      count           <= '0;
      fb_overflow_err <= 1'b0;
    end else begin
      fb_overflow_err <= overflow_d;
      if (exu_flush_final) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
        count  <= '0;
      end else begin
        if (wr_en)  wr_ptr <= wr_ptr + PTR_W'(1);
        if (rd_adv) rd_ptr <= rd_ptr + PTR_W'(1);
        case ({wr_en, rd_adv})
          2'b10:   count <= count + CNT_W'(1);
          2'b01:   count <= count - CNT_W'(1);
          default: count <= count;
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (wr_en) begin
      mem[wr_ptr] <= in_entry;
    end
  end

endmodule

// File: tb/tb_el2_ifu_fetch_buf.sv
// Directed self-checking bench for el2_ifu_fetch_buf (DEPTH=4, default build without bypass).
module tb_el2_ifu_fetch_buf;

  localparam int DEPTH = 4;
  localparam int CNT_W = $clog2(DEPTH+1);

  logic              clk = 1'b0;
  logic              rst_l;
  logic              exu_flush_final;
  logic              ic_hit_f;
  logic [1:0]        ic_fetch_val_f;
  logic [31:0]       ic_data_f;
  logic [1:0]        ic_access_fault_f;
  logic [1:0]        ic_access_fault_type_f;
  logic [31:1]       ifu_fetch_pc_f;
  logic              aln_pop;
  logic              fb_valid;
  logic [31:0]       fb_data;
  logic [1:0]        fb_val;
  logic [31:1]       fb_pc;
  logic [1:0]        fb_fault;
  logic [1:0]        fb_fault_type;
  logic [CNT_W-1:0]  fb_count;
  logic              fb_stall;
  logic              fb_overflow_err;

  int checksTotal  = 0;
  int checksPassed = 0;

  logic [31:0] modelData [$];

  el2_ifu_fetch_buf #(.DEPTH(DEPTH)) dut (
    .clk                    (clk),
    .rst_l                  (rst_l),
    .exu_flush_final        (exu_flush_final),
    .ic_hit_f               (ic_hit_f),
    .ic_fetch_val_f         (ic_fetch_val_f),
    .ic_data_f              (ic_data_f),
    .ic_access_fault_f      (ic_access_fault_f),
    .ic_access_fault_type_f (ic_access_fault_type_f),
    .ifu_fetch_pc_f         (ifu_fetch_pc_f),
    .aln_pop                (aln_pop),
    .fb_valid               (fb_valid),
    .fb_data                (fb_data),
    .fb_val                 (fb_val),
    .fb_pc                  (fb_pc),
    .fb_fault               (fb_fault),
    .fb_fault_type          (fb_fault_type),
    .fb_count               (fb_count),
    .fb_stall               (fb_stall),
    .fb_overflow_err        (fb_overflow_err)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checksTotal++;
    if (got === exp) checksPassed++;
    else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
  endtask

  task automatic applyStimulus(input logic hit, input logic [1:0] val, input logic [31:0] data,
                               input logic [31:1] pc, input logic [1:0] flt, input logic [1:0] fltType,
                               input logic pop, input logic flush);
    ic_hit_f               = hit;
    ic_fetch_val_f         = val;
    ic_data_f              = data;
    ifu_fetch_pc_f         = pc;
    ic_access_fault_f      = flt;
    ic_access_fault_type_f = fltType;
    aln_pop                = pop;
    exu_flush_final        = flush;
  endtask

  task automatic idle();
    applyStimulus(1'b0, 2'b00, 32'h0, 31'h0, 2'b00, 2'b00, 1'b0, 1'b0);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pushEntry(input logic [31:0] data, input logic [31:1] pc, input logic pop);
    applyStimulus(1'b1, 2'b11, data, pc, 2'b00, 2'b00, pop, 1'b0);
    tick();
    idle();
  endtask

  initial begin
    idle();
    rst_l = 1'b0;
    #2;
    checkOutput("reset_valid", 64'(fb_valid), 64'd0);
    checkOutput("reset_count", 64'(fb_count), 64'd0);
    checkOutput("reset_data",  64'(fb_data),  64'd0);
    checkOutput("reset_pc",    64'(fb_pc),    64'd0);
    checkOutput("reset_stall", 64'(fb_stall), 64'd0);
    checkOutput("reset_ovf",   64'(fb_overflow_err), 64'd0);
    tick();
    rst_l = 1'b1;
    tick();
    checkOutput("idle_valid", 64'(fb_valid), 64'd0);

    // Byte PC 0x1000 -> [31:1] = 0x800
    pushEntry(32'hDEADBEEF, 31'h800, 1'b0);
    checkOutput("first_valid", 64'(fb_valid), 64'd1);
    checkOutput("first_pc",    64'(fb_pc),    64'h800);
    checkOutput("first_data",  64'(fb_data),  64'hDEADBEEF);
    checkOutput("first_val",   64'(fb_val),   64'b11);
    checkOutput("first_count", 64'(fb_count), 64'd1);
    applyStimulus(1'b0, 2'b00, 32'h0, 31'h0, 2'b00, 2'b00, 1'b1, 1'b0);
    tick();
    idle();
    checkOutput("pop_count", 64'(fb_count), 64'd0);
    checkOutput("pop_valid", 64'(fb_valid), 64'd0);

    // Fill to DEPTH; stall must rise once count reaches DEPTH-1
    for (int i = 0; i < DEPTH; i++) begin
      pushEntry(32'hA000_0000 + 32'(i), 31'h100 + 31'(i), 1'b0);
      modelData.push_back(32'hA000_0000 + 32'(i));
      checkOutput($sformatf("fill_count%0d", i), 64'(fb_count), 64'(i + 1));
      checkOutput($sformatf("fill_stall%0d", i), 64'(fb_stall), (i >= 2) ? 64'd1 : 64'd0);
    end
    checkOutput("full_head", 64'(fb_data), 64'hA000_0000);

    pushEntry(32'hBAD0_0000, 31'h1FF, 1'b0);
    checkOutput("ovf_pulse", 64'(fb_overflow_err), 64'd1);
    checkOutput("ovf_count", 64'(fb_count), 64'd4);
    tick();
    checkOutput("ovf_clear", 64'(fb_overflow_err), 64'd0);
    checkOutput("ovf_head",  64'(fb_data), 64'hA000_0000);

    // Full with simultaneous push+pop, continued long enough for both pointers to wrap
    for (int i = 0; i < 11; i++) begin
      pushEntry(32'hB000_0000 + 32'(i), 31'h200 + 31'(i), 1'b1);
      void'(modelData.pop_front());
      modelData.push_back(32'hB000_0000 + 32'(i));
      checkOutput($sformatf("wrap_count%0d", i), 64'(fb_count), 64'd4);
      checkOutput($sformatf("wrap_head%0d", i),  64'(fb_data), 64'(modelData[0]));
    end
    checkOutput("wrap_ovf", 64'(fb_overflow_err), 64'd0);

    applyStimulus(1'b0, 2'b00, 32'h0, 31'h0, 2'b00, 2'b00, 1'b1, 1'b0);
    tick();
    idle();
    checkOutput("pre_flush_count", 64'(fb_count), 64'd3);

    // Flush with concurrent push and pop: valid masked now, nothing survives
    applyStimulus(1'b1, 2'b11, 32'hC0DE_C0DE, 31'h300, 2'b00, 2'b00, 1'b1, 1'b1);
    #1;
    checkOutput("flush_valid_mask", 64'(fb_valid), 64'd0);
    tick();
    idle();
    checkOutput("flush_count", 64'(fb_count), 64'd0);
    checkOutput("flush_valid", 64'(fb_valid), 64'd0);
    checkOutput("flush_stall", 64'(fb_stall), 64'd0);
    tick();
    checkOutput("flush_no_entry", 64'(fb_valid), 64'd0);

    // Access fault without a hit is still captured
    applyStimulus(1'b0, 2'b11, 32'h1234_5678, 31'h400, 2'b01, 2'b10, 1'b0, 1'b0);
    tick();
    idle();
    checkOutput("fault_valid", 64'(fb_valid), 64'd1);
    checkOutput("fault_bits",  64'(fb_fault), 64'b01);
    checkOutput("fault_type",  64'(fb_fault_type), 64'b10);
    checkOutput("fault_data",  64'(fb_data), 64'h1234_5678);
    applyStimulus(1'b0, 2'b00, 32'h0, 31'h0, 2'b00, 2'b00, 1'b1, 1'b0);
    tick();
    idle();

    // Asynchronous reset mid-stream
    pushEntry(32'hE000_0001, 31'h501, 1'b0);
    pushEntry(32'hE000_0002, 31'h502, 1'b0);
    checkOutput("prerst_count", 64'(fb_count), 64'd2);
    #2;
    rst_l = 1'b0;
    #1;
    checkOutput("arst_valid", 64'(fb_valid), 64'd0);
    checkOutput("arst_count", 64'(fb_count), 64'd0);
    checkOutput("arst_data",  64'(fb_data),  64'd0);
    checkOutput("arst_pc",    64'(fb_pc),    64'd0);
    tick();
    rst_l = 1'b1;
    pushEntry(32'hF00D_F00D, 31'h600, 1'b0);
    checkOutput("post_rst_data",  64'(fb_data),  64'hF00D_F00D);
    checkOutput("post_rst_pc",    64'(fb_pc),    64'h600);
    checkOutput("post_rst_count", 64'(fb_count), 64'd1);

    $display("%0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule
